// File: rtl/l2_req_responder_pkg.sv
// Shared encodings and types for the L2 request/response channel stub.
// Request/response message codes, line geometry and the responder FSM state.
package l2_req_responder_pkg;

    localparam int WORD_BITS      = 32;
    localparam int LINE_BITS_DEF  = 128;
    localparam int WORDS_PER_LINE = LINE_BITS_DEF / WORD_BITS;

    localparam logic [1:0] REQ_GETS = 2'd0;
    localparam logic [1:0] REQ_GETM = 2'd1;
    localparam logic [1:0] REQ_PUTS = 2'd2;
    localparam logic [1:0] REQ_PUTM = 2'd3;

    localparam logic [1:0] RSP_DATA   = 2'd1;
    localparam logic [1:0] RSP_EDATA  = 2'd2;
    localparam logic [1:0] RSP_PUTACK = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } l2_responder_state_t;

endpackage

// File: rtl/l2_responder_store.sv
// Direct-indexed line store: one synchronous write port, one combinational
// read port, no reset (contents are undefined until written).
module l2_responder_store #(
    parameter int IDX_BITS  = 6,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  waddr,
    input  logic [LINE_BITS-1:0] wdata,
    input  logic [IDX_BITS-1:0]  raddr,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] mem_q [2**IDX_BITS];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/l2_req_responder.sv
// LLC-side stub for the L2: accepts one coherence request at a time and
// returns the matching response after a fixed, programmable latency.
module l2_req_responder
    import l2_req_responder_pkg::*;
#(
    parameter int ADDR_BITS = 28,
    parameter int LINE_BITS = 128,
    parameter int IDX_BITS  = 6,
    parameter int LAT       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      l2_req_out_valid,
    output logic                      l2_req_out_ready,
    input  logic [1:0]                l2_req_out_coh_msg,
    input  logic [1:0]                l2_req_out_hprot,
    input  logic [ADDR_BITS-1:0]      l2_req_out_addr,
    input  logic [LINE_BITS-1:0]      l2_req_out_line,
    output logic                      l2_rsp_in_valid,
    input  logic                      l2_rsp_in_ready,
    output logic [1:0]                l2_rsp_in_coh_msg,
    output logic [ADDR_BITS-1:0]      l2_rsp_in_addr,
    output logic [LINE_BITS-1:0]      l2_rsp_in_line,
    output logic [3:0]                l2_rsp_in_invack_cnt,
    output logic [WORDS_PER_LINE-1:0] l2_rsp_in_word_mask,
    output logic [15:0]               req_cnt
);

    localparam int CNT_W = $clog2(LAT) + 1;

    l2_responder_state_t state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [1:0]                coh_q, coh_d;
    logic [1:0]                hprot_q, hprot_d;
    logic [ADDR_BITS-1:0]      addr_q, addr_d;
    logic [LINE_BITS-1:0]      line_q, line_d;
    logic [15:0]               req_cnt_q, req_cnt_d;
    logic                      req_ready_q, req_ready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [1:0]                rsp_coh_q, rsp_coh_d;
    logic [ADDR_BITS-1:0]      rsp_addr_q, rsp_addr_d;
    logic [LINE_BITS-1:0]      rsp_line_q, rsp_line_d;
    logic [WORDS_PER_LINE-1:0] rsp_mask_q, rsp_mask_d;

    logic                 store_we;
    logic [LINE_BITS-1:0] store_rdata;

    l2_responder_store #(
        .IDX_BITS  (IDX_BITS),
        .LINE_BITS (LINE_BITS)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (l2_req_out_addr[IDX_BITS-1:0]),
        .wdata (l2_req_out_line),
        .raddr (addr_q[IDX_BITS-1:0]),
        .rdata (store_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        coh_d      = coh_q;
        hprot_d    = hprot_q;
        addr_d     = addr_q;
        line_d     = line_q;
        req_cnt_d  = req_cnt_q;
        rsp_coh_d  = rsp_coh_q;
        rsp_addr_d = rsp_addr_q;
        rsp_line_d = rsp_line_q;
        rsp_mask_d = rsp_mask_q;
        store_we   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (l2_req_out_valid && req_ready_q) begin
                    coh_d    = l2_req_out_coh_msg;
                    hprot_d  = l2_req_out_hprot;
                    addr_d   = l2_req_out_addr;
                    line_d   = l2_req_out_line;
                    cnt_d    = CNT_W'(LAT - 1);
                    state_d  = ST_WAIT;
                    store_we = (l2_req_out_coh_msg == REQ_PUTM);
                    if (req_cnt_q != 16'hFFFF) req_cnt_d = req_cnt_q + 16'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    // Store is read here, so an earlier PUTM to the same index is visible.
                    state_d    = ST_RESP;
                    rsp_addr_d = addr_q;
                    unique case (coh_q)
                        REQ_GETS: begin
                            rsp_coh_d  = RSP_EDATA;
                            rsp_line_d = store_rdata;
                            rsp_mask_d = '1;
                        end
                        REQ_GETM: begin
                            rsp_coh_d  = RSP_DATA;
                            rsp_line_d = store_rdata;
                            rsp_mask_d = '1;
                        end
                        default: begin
                            rsp_coh_d  = RSP_PUTACK;
                            rsp_line_d = '0;
                            rsp_mask_d = '0;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && l2_rsp_in_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs are registered off the next state: no input-to-output path.
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            coh_q       <= '0;
            hprot_q     <= '0;
            addr_q      <= '0;
            line_q      <= '0;
            req_cnt_q   <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_coh_q   <= '0;
            rsp_addr_q  <= '0;
            rsp_line_q  <= '0;
            rsp_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coh_q       <= coh_d;
            hprot_q     <= hprot_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            req_cnt_q   <= req_cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_coh_q   <= rsp_coh_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_line_q  <= rsp_line_d;
            rsp_mask_q  <= rsp_mask_d;
        end
    end

    // hprot and the request line are captured for observability only.
    logic unused_req_fields;
    assign unused_req_fields = ^{hprot_q, line_q};

    assign l2_req_out_ready     = req_ready_q;
    assign l2_rsp_in_valid      = rsp_valid_q;
    assign l2_rsp_in_coh_msg    = rsp_coh_q;
    assign l2_rsp_in_addr       = rsp_addr_q;
    assign l2_rsp_in_line       = rsp_line_q;
    assign l2_rsp_in_invack_cnt = 4'd0;
    assign l2_rsp_in_word_mask  = rsp_mask_q;
    assign req_cnt              = req_cnt_q;

endmodule

// File: tb/tb_l2_req_responder.sv
// Self-checking bench for l2_req_responder: vector table plus scoreboard,
// with hand-written backpressure, mid-flight reset and back-to-back sequences.
module tb_l2_req_responder;
    import l2_req_responder_pkg::*;

    localparam int ADDR_BITS = 28;
    localparam int LINE_BITS = 128;
    localparam int IDX_BITS  = 6;
    localparam int LAT       = 4;

    localparam logic [127:0] L1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] L2 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] L3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] L4 = 128'h0BADC0DE_FEEDFACE_12345678_9ABCDEF0;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      req_valid = 1'b0;
    logic                      req_ready;
    logic [1:0]                req_coh = '0;
    logic [1:0]                req_hprot = '0;
    logic [ADDR_BITS-1:0]      req_addr = '0;
    logic [LINE_BITS-1:0]      req_line = '0;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b0;
    logic [1:0]                rsp_coh;
    logic [ADDR_BITS-1:0]      rsp_addr;
    logic [LINE_BITS-1:0]      rsp_line;
    logic [3:0]                rsp_invack;
    logic [WORDS_PER_LINE-1:0] rsp_mask;
    logic [15:0]               req_cnt;

    l2_req_responder #(
        .ADDR_BITS (ADDR_BITS),
        .LINE_BITS (LINE_BITS),
        .IDX_BITS  (IDX_BITS),
        .LAT       (LAT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .l2_req_out_valid     (req_valid),
        .l2_req_out_ready     (req_ready),
        .l2_req_out_coh_msg   (req_coh),
        .l2_req_out_hprot     (req_hprot),
        .l2_req_out_addr      (req_addr),
        .l2_req_out_line      (req_line),
        .l2_rsp_in_valid      (rsp_valid),
        .l2_rsp_in_ready      (rsp_ready),
        .l2_rsp_in_coh_msg    (rsp_coh),
        .l2_rsp_in_addr       (rsp_addr),
        .l2_rsp_in_line       (rsp_line),
        .l2_rsp_in_invack_cnt (rsp_invack),
        .l2_rsp_in_word_mask  (rsp_mask),
        .req_cnt              (req_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]           coh;
        logic [ADDR_BITS-1:0] addr;
        logic [LINE_BITS-1:0] line;
        logic [1:0]           ecoh;
        logic [LINE_BITS-1:0] eline;
        logic [3:0]           emask;
    } vec_t;

    typedef struct {
        logic [1:0]           coh;
        logic [ADDR_BITS-1:0] addr;
        logic [LINE_BITS-1:0] line;
        logic [3:0]           mask;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   acc_log[$];
    bit   log_acc = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] cnt_model = '0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Response monitor: latency on valid rise, scoreboard compare on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc + 1);
                if (log_acc) acc_log.push_back(cyc + 1);
            end
            if (rsp_valid && !prev_valid) begin
                if (acc_q.size() == 0) chk("latency_no_accept", 128'd1, 128'd0);
                else chk("latency", 128'(cyc - acc_q.pop_front()), 128'(LAT));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 128'd1, 128'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_coh", 128'(rsp_coh), 128'(e.coh));
                    chk("rsp_addr", 128'(rsp_addr), 128'(e.addr));
                    chk("rsp_line", rsp_line, e.line);
                    chk("rsp_mask", 128'(rsp_mask), 128'(e.mask));
                    chk("rsp_invack", 128'(rsp_invack), 128'd0);
                end
            end
            prev_valid = rsp_valid;
        end
    end

    // Called #1 after a posedge. Returns #1 after the accept edge.
    task automatic send(input logic [1:0] coh, input logic [ADDR_BITS-1:0] addr,
                        input logic [LINE_BITS-1:0] line, input logic [1:0] ecoh,
                        input logic [LINE_BITS-1:0] eline, input logic [3:0] emask,
                        input bit keep);
        exp_t e;
        int n;
        req_valid = 1'b1;
        req_coh   = coh;
        req_addr  = addr;
        req_line  = line;
        req_hprot = 2'b10;
        e.coh = ecoh; e.addr = addr; e.line = eline; e.mask = emask;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) chk("accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
        if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        chk("req_cnt", 128'(req_cnt), 128'(cnt_model));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vt[8];

    initial begin
        int n;
        bit seen;
        vt[0] = '{REQ_PUTM, 28'h0000010, L1, RSP_PUTACK, '0, 4'h0};
        vt[1] = '{REQ_GETS, 28'h0000010, '0, RSP_EDATA,  L1, 4'hF};
        vt[2] = '{REQ_GETM, 28'h0000050, '0, RSP_DATA,   L1, 4'hF};
        vt[3] = '{REQ_PUTM, 28'h000003F, L2, RSP_PUTACK, '0, 4'h0};
        vt[4] = '{REQ_GETM, 28'h0ABCDFF, '0, RSP_DATA,   L2, 4'hF};
        vt[5] = '{REQ_PUTS, 28'h0000010, L3, RSP_PUTACK, '0, 4'h0};
        vt[6] = '{REQ_GETS, 28'h0000010, '0, RSP_EDATA,  L1, 4'hF};
        vt[7] = '{REQ_GETS, 28'hFFFFFFF, L3, RSP_EDATA,  L2, 4'hF};

        // Reset state
        #3;
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_req_cnt", 128'(req_cnt), 128'd0);
        chk("rst_rsp_line", rsp_line, 128'd0);
        chk("rst_rsp_coh", 128'(rsp_coh), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 128'(req_ready), 128'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send(vt[i].coh, vt[i].addr, vt[i].line, vt[i].ecoh, vt[i].eline, vt[i].emask, 1'b0);
        end
        drain();

        // Backpressure: response must hold for 20+ cycles with ready low.
        rsp_ready = 1'b0;
        send(REQ_GETS, 28'h0000010, '0, RSP_EDATA, L1, 4'hF, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 128'(rsp_valid), 128'd1);
            chk("bp_req_ready", 128'(req_ready), 128'd0);
            chk("bp_coh", 128'(rsp_coh), 128'(RSP_EDATA));
            chk("bp_line", rsp_line, L1);
            chk("bp_addr", 128'(rsp_addr), 128'h10);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_dropped", 128'(rsp_valid), 128'd0);
        chk("bp_ready_back", 128'(req_ready), 128'd1);
        @(posedge clk);
        #1;

        // Reset while a PUTM sits in WAIT: no response, but the write has committed.
        send(REQ_PUTM, 28'h0000005, L4, RSP_PUTACK, '0, 4'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        cnt_model = '0;
        #1;
        chk("mid_rst_valid", 128'(rsp_valid), 128'd0);
        chk("mid_rst_ready", 128'(req_ready), 128'd0);
        chk("mid_rst_cnt", 128'(req_cnt), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("mid_rst_no_rsp", 128'(seen), 128'd0);
        chk("mid_rst_ready_after", 128'(req_ready), 128'd1);
        chk("mid_rst_cnt_after", 128'(req_cnt), 128'd0);
        @(posedge clk);
        #1;

        // Back-to-back with request valid held: accept, LAT to response,
        // handshake one edge later, ready the cycle after -> LAT+2 edges apart.
        log_acc = 1'b1;
        send(REQ_GETS, 28'h0000010, '0, RSP_EDATA, L1, 4'hF, 1'b1);
        send(REQ_GETS, 28'h0000050, '0, RSP_EDATA, L1, 4'hF, 1'b1);
        send(REQ_GETS, 28'h000003F, '0, RSP_EDATA, L2, 4'hF, 1'b0);
        drain();
        log_acc = 1'b0;
        chk("b2b_accepts", 128'(acc_log.size()), 128'd3);
        if (acc_log.size() == 3) begin
            chk("b2b_gap0", 128'(acc_log[1] - acc_log[0]), 128'(LAT + 2));
            chk("b2b_gap1", 128'(acc_log[2] - acc_log[1]), 128'(LAT + 2));
        end
        chk("b2b_req_cnt", 128'(req_cnt), 128'd3);

        send(REQ_GETS, 28'h0000005, '0, RSP_EDATA, L4, 4'hF, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
